// File: rtl/gb_conv.sv
`default_nettype none
// ============================================================================
// Module      : gb_conv
// Description : Gray-to-binary converter with a registered output stage.
//               Optional build macro GB_CONV_BIN2GRAY_EN adds a dir input
//               that selects binary-to-Gray conversion when dir=1.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_conv #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [size-1:0] gray,
`ifdef GB_CONV_BIN2GRAY_EN
  input  logic            dir,
`endif
  output logic [size-1:0] bin,
  output logic            out_valid
);

  logic [size-1:0] g2b_w;
  logic [size-1:0] conv_w;
  logic [size-1:0] bin_d;
  logic [size-1:0] bin_q;
  logic            out_valid_d;
  logic            out_valid_q;

  // Prefix-XOR from the MSB down: each binary bit is the parity of all Gray bits at or above it
  always_comb begin
    logic acc;
    acc   = 1'b0;
    g2b_w = '0;
    for (int i = size - 1; i >= 0; i--) begin
      acc      = acc ^ gray[i];
      g2b_w[i] = acc;
    end
  end

`ifdef GB_CONV_BIN2GRAY_EN
  // Direction select: dir=1 encodes binary to Gray, dir=0 decodes Gray to binary
  always_comb begin
    conv_w = dir ? (gray ^ (gray >> 1)) : g2b_w;
  end
`else
  // Decode-only build
  always_comb begin
    conv_w = g2b_w;
  end
`endif

  // Next-state: load on a qualified input, otherwise hold so unqualified (possibly X) data never reaches bin
  always_comb begin
    bin_d       = bin_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      bin_d       = conv_w;
      out_valid_d = 1'b1;
    end
  end

  // Output registers; reset dominates any input presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bin       = bin_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gb_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_conv
// Description : Directed, table-driven bench for gb_conv (sizes 4, 1 and 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_conv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] gray4 = '0;
  logic [0:0] gray1 = '0;
  logic [7:0] gray8 = '0;
  logic       dir = 1'b0;
  logic [3:0] bin4;
  logic [0:0] bin1;
  logic [7:0] bin8;
  logic       ov4, ov1, ov8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gb_conv #(.size(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray(gray4),
`ifdef GB_CONV_BIN2GRAY_EN
    .dir(dir),
`endif
    .bin(bin4), .out_valid(ov4)
  );

  gb_conv #(.size(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray(gray1),
`ifdef GB_CONV_BIN2GRAY_EN
    .dir(dir),
`endif
    .bin(bin1), .out_valid(ov1)
  );

  gb_conv #(.size(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray(gray8),
`ifdef GB_CONV_BIN2GRAY_EN
    .dir(dir),
`endif
    .bin(bin8), .out_valid(ov8)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] g;
    logic [3:0] exp_bin;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [3:0] g,
                     input logic [3:0] eb, input logic eo);
    vec_t t;
    t.rst = r; t.vld = v; t.g = g; t.exp_bin = eb; t.exp_ov = eo;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge
  task automatic step(input logic r, input logic v);
    rst = r;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] sweep [16];
    sweep = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Reset held 2 cycles with a qualified input that must be discarded
    add(1, 1, 4'b1111, 4'b0000, 0);
    add(1, 1, 4'b1111, 4'b0000, 0);
    // First cycle out of reset with no input: no out_valid
    add(0, 0, 4'b1111, 4'b0000, 0);
    // Full back-to-back sweep: bin counts 0..15
    for (int i = 0; i < 16; i++) add(0, 1, sweep[i], 4'(i), 1);
    // Spot values
    add(0, 1, 4'b1101, 4'b1001, 1);
    add(0, 1, 4'b1000, 4'b1111, 1);
    add(0, 1, 4'b0100, 4'b0111, 1);
    // Reset mid-stream: capture, then a reset cycle with valid input, then idle
    add(0, 1, 4'b0110, 4'b0100, 1);
    add(1, 1, 4'b0011, 4'b0000, 0);
    add(0, 0, 4'b0011, 4'b0000, 0);

    // Initial reset edge before the table
    step(1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      gray4 = vecs[i].g;
      step(vecs[i].rst, vecs[i].vld);
      chk($sformatf("vec%0d_bin", i), 64'(bin4), 64'(vecs[i].exp_bin));
      chk($sformatf("vec%0d_ov", i), 64'(ov4), 64'(vecs[i].exp_ov));
    end

    // Hold: capture 1010 -> 1100, then 3 gap cycles with changing/X gray
    gray4 = 4'b1010;
    step(0, 1);
    chk("hold_capture_bin", 64'(bin4), 64'(4'b1100));
    chk("hold_capture_ov", 64'(ov4), 64'(1'b1));
    for (int k = 0; k < 3; k++) begin
      gray4 = (k == 1) ? 4'bxxxx : 4'($urandom_range(0, 15));
      step(0, 0);
      chk($sformatf("hold%0d_bin", k), 64'(bin4), 64'(4'b1100));
      chk($sformatf("hold%0d_ov", k), 64'(ov4), 64'(1'b0));
    end

    // Width corners
    gray4 = 4'b0000;
    gray1 = 1'b1;
    gray8 = 8'h80;
    step(0, 1);
    chk("size1_bin", 64'(bin1), 64'(1'b1));
    chk("size1_ov", 64'(ov1), 64'(1'b1));
    chk("size8_80_bin", 64'(bin8), 64'(8'hFF));
    gray1 = 1'b0;
    gray8 = 8'hC0;
    step(0, 1);
    chk("size1_zero_bin", 64'(bin1), 64'(1'b0));
    chk("size8_C0_bin", 64'(bin8), 64'(8'h80));
    chk("size8_ov", 64'(ov8), 64'(1'b1));
    step(0, 0);
    chk("size8_idle_ov", 64'(ov8), 64'(1'b0));
    chk("size8_idle_bin", 64'(bin8), 64'(8'h80));

`ifdef GB_CONV_BIN2GRAY_EN
    // Round trip: encode 1001 -> 1101, then decode 1101 -> 1001
    dir = 1'b1;
    gray4 = 4'b1001;
    gray8 = 8'hFF;
    step(0, 1);
    chk("b2g_bin", 64'(bin4), 64'(4'b1101));
    chk("b2g_size8_bin", 64'(bin8), 64'(8'h80));
    dir = 1'b0;
    gray4 = 4'b1101;
    step(0, 1);
    chk("g2b_roundtrip_bin", 64'(bin4), 64'(4'b1001));
    chk("g2b_roundtrip_ov", 64'(ov4), 64'(1'b1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gb_conv.md
# gb_conv

Parameterised Gray-code-to-binary converter with a registered output stage. It sits on the datapath between a Gray-coded source (encoder counter, async-FIFO pointer, rotary sensor) and binary consumers. It accepts one Gray word per qualified cycle and presents the binary equivalent one clock later.

## Interface
Parameters:
- size, default 4, data width in bits for both the Gray input and the binary output; legal range 1..64.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
- in_valid  input  1  qualifies gray for capture this cycle.
- gray  input  size  Gray-coded input word.
- bin  output  size  binary equivalent of the last captured gray word, registered.
- out_valid  output  1  high for exactly one cycle after each capture.
- dir  input  1  direction select; present only when GB_CONV_BIN2GRAY_EN is defined (see Configuration).

## Operation
- Conversion (Gray to binary) is a prefix-XOR from the MSB down:
  - bin[size-1] = gray[size-1]
  - bin[i] = bin[i+1] XOR gray[i], for i = size-2 down to 0.
- The result is computed combinationally from gray.
- On a rising edge with rst=0 and in_valid=1:
  - the bin register loads the converted value;
  - out_valid register loads 1.
- On a rising edge with rst=0 and in_valid=0:
  - bin holds its previous value;
  - out_valid loads 0.
- There is no backpressure. Every qualified input is converted; the consumer must accept a result on the cycle out_valid is high.
- Width rules:
  - The output is exactly size bits; no carry or overflow exists.
  - With size=1, bin equals gray.
- X on gray while in_valid=0 must not propagate into bin.

## Timing
- Reset: on a rising edge with rst=1, bin := 0 and out_valid := 0. Reset dominates in_valid in the same cycle.
- Reset mid-stream: an input presented in the same cycle as rst=1 is discarded. No out_valid follows it.
- Latency:
  - Exactly 1 clock, from the edge capturing gray/in_valid to bin/out_valid being visible after that edge.
  - The combinational path is gray to the bin D-input only; no combinational path exists from input to output ports.
- Throughput: one word per clock. Back-to-back in_valid cycles produce back-to-back out_valid cycles, each bin matching its own input.
- Holding behaviour: after the last valid input, bin stays stable until the next capture or reset.

## Configuration
- Macro: GB_CONV_BIN2GRAY_EN.
- Defined:
  - Port dir is present.
  - dir=0 selects Gray-to-binary, as described above.
  - dir=1 selects binary-to-Gray: the output is gray XOR (gray >> 1), i.e. out[size-1] = in[size-1] and out[i] = in[i+1] XOR in[i].
  - dir is sampled together with in_valid and has the same 1-cycle latency.
  - Reset values are unchanged.
- Not defined:
  - Port dir is absent.
  - The block performs Gray-to-binary only.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 and gray=4'b1111 -> bin=4'b0000 and out_valid=0 throughout; no out_valid on the cycle after rst deasserts unless in_valid is high.
- Full sweep, size=4: apply gray 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000 back-to-back with in_valid=1 -> bin = 0, 1, 2, … 15 in order, each one cycle later, with out_valid continuously high.
- Spot values: gray 4'b1101 -> bin 4'b1001; gray 4'b1000 -> bin 4'b1111; gray 4'b0100 -> bin 4'b0111.
- Hold / gaps: capture gray 4'b1010 (giving bin 4'b1100), then drive in_valid=0 for 3 cycles with gray toggling randomly -> bin stays 4'b1100 and out_valid=0 for those cycles.
- Width corners: size=1 with gray 1 -> bin 1; size=8 with gray 8'h80 -> bin 8'hFF, and gray 8'hC0 -> bin 8'h80.
- With GB_CONV_BIN2GRAY_EN defined, dir=1: input 4'b1001 -> output 4'b1101; then dir=0 with input 4'b1101 -> output 4'b1001 (round trip).
